// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (port 0) always wins, secondary
// producers share idle cycles round-robin, and a starvation counter requests a bubble.
module riscv_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int NUM_SEC      = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    p0_valid,
    input  logic [4:0]              p0_rd,
    input  logic [XLEN-1:0]         p0_data,
    input  logic [NUM_SEC-1:0]      sec_valid,
    input  logic [5*NUM_SEC-1:0]    sec_rd,
    input  logic [XLEN*NUM_SEC-1:0] sec_data,
    output logic [NUM_SEC-1:0]      sec_ready,
    output logic                    stall_req,
    output logic                    rf_we,
    output logic [4:0]              rf_waddr,
    output logic [XLEN-1:0]         rf_wdata
);

    localparam int PW = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0]      r_rr_ptr;
    logic [CW-1:0]      r_wait_cnt;
    logic               r_rf_we;
    logic [4:0]         r_rf_waddr;
    logic [XLEN-1:0]    r_rf_wdata;

    logic               w_found;
    logic [NUM_SEC-1:0] w_grant;
    logic [PW-1:0]      w_next_ptr;
    logic [4:0]         w_sec_rd;
    logic [XLEN-1:0]    w_sec_data;

    // Pass 0 scans rr_ptr..NUM_SEC-1, pass 1 wraps to the lowest valid index.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_next_ptr = r_rr_ptr;
        w_sec_rd   = '0;
        w_sec_data = '0;
        if (rst_n && !p0_valid) begin
            for (int p = 0; p < 2; p++) begin
                for (int i = 0; i < NUM_SEC; i++) begin
                    if (!w_found && sec_valid[i] && (p == 1 || i >= int'(r_rr_ptr))) begin
                        w_found    = 1'b1;
                        w_grant[i] = 1'b1;
                        w_sec_rd   = sec_rd[5*i +: 5];
                        w_sec_data = sec_data[XLEN*i +: XLEN];
                        w_next_ptr = (i == NUM_SEC - 1) ? '0 : PW'(i + 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rr_ptr   <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (p0_valid) begin
                r_rf_we <= (p0_rd != 5'd0);
            end else if (w_found) begin
                r_rf_we <= (w_sec_rd != 5'd0);
            end else begin
                r_rf_we <= 1'b0;
            end

            if (w_found) begin
                r_rr_ptr <= w_next_ptr;
            end

            if (|sec_valid && !w_found) begin
                if (r_wait_cnt != CW'(STARVE_LIMIT)) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Address/data are don't-care while rf_we is low, so they carry no reset.
    always_ff @(posedge clk) begin
        if (p0_valid) begin
            r_rf_waddr <= p0_rd;
            r_rf_wdata <= p0_data;
        end else if (w_found) begin
            r_rf_waddr <= w_sec_rd;
            r_rf_wdata <= w_sec_data;
        end
    end

    assign sec_ready = w_grant;
    assign stall_req = (r_wait_cnt == CW'(STARVE_LIMIT));
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;

    a_no_p0_during_stall: assert property (@(posedge clk) disable iff (!rst_n)
        stall_req |-> !p0_valid);
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(sec_ready));

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter: reset, p0 writeback, collision, round-robin,
// starvation stall and x0 handling, with hand-computed expectations.
module tb_riscv_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_valid;
    logic [4:0]  p0_rd;
    logic [31:0] p0_data;
    logic [1:0]  sec_valid;
    logic [9:0]  sec_rd;
    logic [63:0] sec_data;
    logic [1:0]  sec_ready;
    logic        stall_req;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int checks = 0;
    int errors = 0;

    riscv_wb_arbiter #(.XLEN(32), .NUM_SEC(2), .STARVE_LIMIT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_valid  (p0_valid),
        .p0_rd     (p0_rd),
        .p0_data   (p0_data),
        .sec_valid (sec_valid),
        .sec_rd    (sec_rd),
        .sec_data  (sec_data),
        .sec_ready (sec_ready),
        .stall_req (stall_req),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic p0v, input logic [4:0] p0r, input logic [31:0] p0d,
                         input logic [1:0] sv, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [31:0] d0, input logic [31:0] d1);
        p0_valid  = p0v;
        p0_rd     = p0r;
        p0_data   = p0d;
        sec_valid = sv;
        sec_rd    = {r1, r0};
        sec_data  = {d1, d0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("init_we", {63'd0, rf_we}, 64'd0);
        check("init_stall", {63'd0, stall_req}, 64'd0);
        check("init_ready", {62'd0, sec_ready}, 64'd0);
        rst_n = 1'b1;

        // p0 only
        @(negedge clk);
        drive(1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1 check("p0_ready", {62'd0, sec_ready}, 64'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        check("p0_we", {63'd0, rf_we}, 64'd1);
        check("p0_waddr", {59'd0, rf_waddr}, 64'd5);
        check("p0_wdata", {32'd0, rf_wdata}, 64'hDEADBEEF);
        @(negedge clk);
        #1 check("p0_idle_we", {63'd0, rf_we}, 64'd0);

        // round-robin, both secondaries requesting every cycle
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd11, 32'hA0A0, 32'hB1B1);
            #1;
            check($sformatf("rr_ready%0d", k), {62'd0, sec_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
            if (k > 0) begin
                check($sformatf("rr_we%0d", k), {63'd0, rf_we}, 64'd1);
                check($sformatf("rr_waddr%0d", k), {59'd0, rf_waddr}, (k % 2 == 1) ? 64'd10 : 64'd11);
            end
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        check("rr_last_we", {63'd0, rf_we}, 64'd1);
        check("rr_last_waddr", {59'd0, rf_waddr}, 64'd11);
        check("rr_last_wdata", {32'd0, rf_wdata}, 64'hB1B1);

        // x0 destination: consumed, not written, pointer advances
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 32'h1234, 32'h0);
        #1 check("x0_ready", {62'd0, sec_ready}, 64'd1);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd9, 5'd12, 32'h9999, 32'hCCCC);
        #1;
        check("x0_we", {63'd0, rf_we}, 64'd0);
        check("x0_ptr", {62'd0, sec_ready}, 64'd2);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        check("x0_next_we", {63'd0, rf_we}, 64'd1);
        check("x0_next_waddr", {59'd0, rf_waddr}, 64'd12);

        // collision: p0 and sec0 together, p0 idle next cycle
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h33, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0);
        #1 check("col_ready_t", {62'd0, sec_ready}, 64'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0);
        #1;
        check("col_ready_t1", {62'd0, sec_ready}, 64'd1);
        check("col_waddr_t1", {59'd0, rf_waddr}, 64'd3);
        check("col_wdata_t1", {32'd0, rf_wdata}, 64'h33);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        check("col_we_t2", {63'd0, rf_we}, 64'd1);
        check("col_waddr_t2", {59'd0, rf_waddr}, 64'd7);
        check("col_wdata_t2", {32'd0, rf_wdata}, 64'h77);

        // starvation: p0 busy cycles 0..7, sec1 waiting from cycle 0
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(k + 1), 32'h1000 + k, 2'b10, 5'd0, 5'd20, 32'h0, 32'hC0FFEE);
            #1;
            check($sformatf("st_stall%0d", k), {63'd0, stall_req}, 64'd0);
            check($sformatf("st_ready%0d", k), {62'd0, sec_ready}, 64'd0);
            if (k > 0) check($sformatf("st_waddr%0d", k), {59'd0, rf_waddr}, 64'(k));
        end
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd20, 32'h0, 32'hC0FFEE);
        #1;
        check("st_stall8", {63'd0, stall_req}, 64'd1);
        check("st_ready8", {62'd0, sec_ready}, 64'd2);
        check("st_wdata8", {32'd0, rf_wdata}, 64'h1007);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        check("st_stall9", {63'd0, stall_req}, 64'd0);
        check("st_we9", {63'd0, rf_we}, 64'd1);
        check("st_waddr9", {59'd0, rf_waddr}, 64'd20);
        check("st_wdata9", {32'd0, rf_wdata}, 64'hC0FFEE);

        // reset mid-stream with both secondaries requesting
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b01, 5'd4, 5'd0, 32'h4444, 32'h0);
        #1 check("mr_ready0", {62'd0, sec_ready}, 64'd1);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b11, 5'd4, 5'd6, 32'h4444, 32'h6666);
        #1;
        check("mr_ready1", {62'd0, sec_ready}, 64'd2);
        check("mr_we1", {63'd0, rf_we}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_rst_we", {63'd0, rf_we}, 64'd0);
        check("mr_rst_stall", {63'd0, stall_req}, 64'd0);
        check("mr_rst_ready", {62'd0, sec_ready}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("mr_first_ready", {62'd0, sec_ready}, 64'd1);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        #1;
        check("mr_first_we", {63'd0, rf_we}, 64'd1);
        check("mr_first_waddr", {59'd0, rf_waddr}, 64'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
